// File: rtl/mult_bus_master.sv
// Command-driven bus master: writes two operands to a multiplier responder,
// starts it, waits (bounded) for the result and returns it as a response.
module mult_bus_master #(
  parameter int WRITE_HOLD = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        bus_valid,
  output logic        bus_start,
  output logic [31:0] bus_address,
  output logic [31:0] bus_data,
  input  logic        bus_ready,
  input  logic [31:0] bus_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a valid source holds its payload stable until that edge.

  localparam int HW = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(WRITE_HOLD - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_A = 3'd1,
    S_WR_B = 3'd2,
    S_RUN  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic [TW-1:0] r_wait;
  logic [TW-1:0] w_wait_nxt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          w_capture;
  logic          w_timeout;
  logic          w_accept;

  logic          r_bus_valid;
  logic          r_bus_start;
  logic [31:0]   r_bus_address;
  logic [31:0]   r_bus_data;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_err;

  logic          w_bus_valid;
  logic          w_bus_start;
  logic [31:0]   w_bus_address;
  logic [31:0]   w_bus_data;

  assign cmd_ready   = (r_state == S_IDLE) && !rst;
  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign bus_valid   = r_bus_valid;
  assign bus_start   = r_bus_start;
  assign bus_address = r_bus_address;
  assign bus_data    = r_bus_data;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_wait_nxt  = r_wait;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = S_WR_A;
          w_hold_nxt  = '0;
        end
      end
      S_WR_A: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = S_WR_B;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      S_WR_B: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = S_RUN;
          w_wait_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      S_RUN: begin
        // A ready in the last counted cycle is checked first, so it beats the timeout.
        if (bus_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered images of the state being entered.
  always_comb begin
    w_bus_valid   = 1'b0;
    w_bus_start   = 1'b0;
    w_bus_address = 32'd0;
    w_bus_data    = 32'd0;
    case (w_state_nxt)
      S_WR_A: begin
        w_bus_valid   = 1'b1;
        w_bus_address = 32'd1;
        w_bus_data    = (r_state == S_IDLE) ? cmd_a : r_a;
      end
      S_WR_B: begin
        w_bus_valid   = 1'b1;
        w_bus_address = 32'd2;
        w_bus_data    = r_b;
      end
      S_RUN: begin
        w_bus_valid = 1'b1;
        w_bus_start = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_hold        <= '0;
      r_wait        <= '0;
      r_a           <= 32'd0;
      r_b           <= 32'd0;
      r_bus_valid   <= 1'b0;
      r_bus_start   <= 1'b0;
      r_bus_address <= 32'd0;
      r_bus_data    <= 32'd0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= 32'd0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_wait        <= w_wait_nxt;
      r_bus_valid   <= w_bus_valid;
      r_bus_start   <= w_bus_start;
      r_bus_address <= w_bus_address;
      r_bus_data    <= w_bus_data;
      r_rsp_valid   <= (w_state_nxt == S_RESP);
      if (w_accept) begin
        r_a <= cmd_a;
        r_b <= cmd_b;
      end
      if (w_capture) begin
        r_rsp_data <= bus_result;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= 32'd0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_bus_master.sv
// Directed bench for mult_bus_master with a multiplier responder model and
// an in-order response scoreboard.
module tb_mult_bus_master;
  localparam int WH = 2;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        bus_valid;
  logic        bus_start;
  logic [31:0] bus_address;
  logic [31:0] bus_data;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_result = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  logic [32:0] exp_q[$];

  // Responder model controls
  logic [31:0] resp_a = 32'd0;
  logic [31:0] resp_b = 32'd0;
  int          run_n = 0;
  int          resp_delay = 0;
  bit          stray_en = 1'b0;

  mult_bus_master #(.WRITE_HOLD(WH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .bus_valid(bus_valid), .bus_start(bus_start), .bus_address(bus_address),
    .bus_data(bus_data), .bus_ready(bus_ready), .bus_result(bus_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: latches operand writes, raises ready in RUN cycle resp_delay
  // (1-based; 0 = never), optionally a stray ready during operand-A writes.
  always @(negedge clk) begin
    if (bus_valid && bus_address == 32'd1) resp_a = bus_data;
    if (bus_valid && bus_address == 32'd2) resp_b = bus_data;
    if (bus_valid && bus_start) run_n++;
    else run_n = 0;
    bus_ready  = (bus_valid && bus_start && run_n == resp_delay) ||
                 (stray_en && bus_valid && bus_address == 32'd1);
    bus_result = (bus_valid && bus_start) ? resp_a * resp_b : 32'hdead_beef;
  end

  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      n_rsp++;
      chk("rsp_expected", 33'(exp_q.size() != 0), 33'(1));
      if (exp_q.size() != 0) chk("rsp_scoreboard", {rsp_err, rsp_data}, exp_q.pop_front());
    end
  end

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", 33'(cmd_ready), 33'(1));
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 33'(rsp_valid), 33'(1));
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_start;
    int          k;
    int          runs;
    int          gap;
    bit          saw;

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 32'd0; cmd_b = 32'd0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 33'(cmd_ready), 33'(0));
    chk("rst_bus_valid", 33'(bus_valid), 33'(0));
    chk("rst_bus_start", 33'(bus_start), 33'(0));
    chk("rst_bus_addr", 33'(bus_address), 33'(0));
    chk("rst_bus_data", 33'(bus_data), 33'(0));
    chk("rst_rsp_valid", 33'(rsp_valid), 33'(0));
    chk("rst_rsp_data", 33'(rsp_data), 33'(0));
    chk("rst_rsp_err", 33'(rsp_err), 33'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 33'(cmd_ready), 33'(1));

    // Normal transaction 6*7, ready in the third RUN cycle
    resp_delay = 3;
    exp_q.push_back({1'b0, 32'd42});
    send_cmd(32'd6, 32'd7);
    for (int c = 1; c <= 7; c++) begin
      exp_addr  = (c <= 2) ? 32'd1 : (c <= 4) ? 32'd2 : 32'd0;
      exp_data  = (c <= 2) ? 32'd6 : (c <= 4) ? 32'd7 : 32'd0;
      exp_start = (c >= 5);
      chk($sformatf("norm_valid_c%0d", c), 33'(bus_valid), 33'(1));
      chk($sformatf("norm_addr_c%0d", c), 33'(bus_address), 33'(exp_addr));
      chk($sformatf("norm_data_c%0d", c), 33'(bus_data), 33'(exp_data));
      chk($sformatf("norm_start_c%0d", c), 33'(bus_start), 33'(exp_start));
      chk($sformatf("norm_no_rsp_c%0d", c), 33'(rsp_valid), 33'(0));
      @(negedge clk);
    end
    chk("norm_rsp_valid", 33'(rsp_valid), 33'(1));
    chk("norm_rsp_data", 33'(rsp_data), 33'(42));
    chk("norm_rsp_err", 33'(rsp_err), 33'(0));
    chk("norm_resp_bus_valid", 33'(bus_valid), 33'(0));
    @(negedge clk);
    chk("norm_rsp_cleared", 33'(rsp_valid), 33'(0));
    chk("norm_back_idle", 33'(cmd_ready), 33'(1));

    // Minimum latency plus backpressure: 9*11, ready in the first RUN cycle
    rsp_ready  = 1'b0;
    resp_delay = 1;
    exp_q.push_back({1'b0, 32'd99});
    send_cmd(32'd9, 32'd11);
    k = 1;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("min_latency", 33'(k), 33'(2 * WH + 2));
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 33'(rsp_valid), 33'(1));
      chk($sformatf("bp_data_c%0d", c), 33'(rsp_data), 33'(99));
      chk($sformatf("bp_cmd_ready_c%0d", c), 33'(cmd_ready), 33'(0));
      cmd_valid = (c == 2);
      cmd_a     = 32'd1;
      cmd_b     = 32'd2;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 33'(rsp_valid), 33'(0));
    chk("bp_idle_ready", 33'(cmd_ready), 33'(1));
    @(negedge clk);
    chk("bp_cmd_not_queued", 33'(bus_valid), 33'(0));

    // Timeout: ready never arrives
    resp_delay = 0;
    exp_q.push_back({1'b1, 32'd0});
    send_cmd(32'd2, 32'd3);
    runs = 0;
    k = 0;
    while (!rsp_valid && k < 100) begin
      if (bus_start) runs++;
      @(negedge clk);
      k++;
    end
    chk("to_run_cycles", 33'(runs), 33'(TO));
    chk("to_rsp_valid", 33'(rsp_valid), 33'(1));
    chk("to_rsp_err", 33'(rsp_err), 33'(1));
    chk("to_rsp_data", 33'(rsp_data), 33'(0));

    // Ready in the last counted RUN cycle wins over the timeout
    resp_delay = TO;
    exp_q.push_back({1'b0, 32'd20});
    send_cmd(32'd4, 32'd5);
    wait_rsp("last_cycle_rsp_seen");
    chk("last_cycle_err", 33'(rsp_err), 33'(0));
    chk("last_cycle_data", 33'(rsp_data), 33'(20));
    @(negedge clk);

    // Reset in the first WR_B cycle aborts silently
    resp_delay = 1;
    send_cmd(32'd8, 32'd8);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wr_b", 33'(bus_address), 33'(2));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bus_valid", 33'(bus_valid), 33'(0));
    chk("abort_bus_start", 33'(bus_start), 33'(0));
    chk("abort_cmd_ready_rst", 33'(cmd_ready), 33'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", 33'(cmd_ready), 33'(1));
    saw = 1'b0;
    repeat (10) begin
      if (rsp_valid) saw = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_rsp", 33'(saw), 33'(0));

    // Stray ready during WR_A is ignored: 7*11
    stray_en   = 1'b1;
    resp_delay = 2;
    exp_q.push_back({1'b0, 32'd77});
    send_cmd(32'd7, 32'd11);
    wait_rsp("stray_rsp_seen");
    chk("stray_data", 33'(rsp_data), 33'(77));
    chk("stray_err", 33'(rsp_err), 33'(0));
    stray_en = 1'b0;
    @(negedge clk);

    // Back-to-back: cmd_valid held high across two commands, 3*5 then 4*6
    resp_delay = 1;
    exp_q.push_back({1'b0, 32'd15});
    exp_q.push_back({1'b0, 32'd24});
    send_cmd(32'd3, 32'd5);
    cmd_valid = 1'b1;
    cmd_a     = 32'd4;
    cmd_b     = 32'd6;
    k = 0;
    while (bus_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    gap = 0;
    while (!bus_valid && k < 100) begin
      gap++;
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    chk("b2b_gap_present", 33'(gap >= 1), 33'(1));
    chk("b2b_second_started", 33'(bus_address), 33'(1));
    chk("b2b_second_data", 33'(bus_data), 33'(4));
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 33'(exp_q.size()), 33'(0));
    chk("rsp_count", 33'(n_rsp), 33'(7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
